// File: rtl/de_scoreboard.sv
// Decode-side register scoreboard: tracks in-flight writes from DE issue to WB retire and stalls DE on RAW/WAW hazards.
// Optional SB_STALL_CNT_EN adds a saturating 32-bit stall-cycle counter output sb_stall_cnt.
module de_sb_slot #(
  parameter int CNT_BITS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                inc,
  input  logic                wb_hit,
  output logic [CNT_BITS-1:0] cnt,
  output logic                busy,
  output logic                underflow
);
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                dec;

  always_comb begin
    dec       = wb_hit & (cnt_q != '0);
    underflow = wb_hit & (cnt_q == '0);
    cnt_d     = cnt_q + CNT_BITS'(inc) - CNT_BITS'(dec);
    busy_d    = (cnt_d != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign cnt  = cnt_q;
  assign busy = busy_q;
endmodule

module de_scoreboard #(
  parameter int NREGS    = 32,
  parameter int REGBITS  = 5,
  parameter int CNT_BITS = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               de_valid,
  input  logic [REGBITS-1:0] de_rs1,
  input  logic               de_rs1_used,
  input  logic [REGBITS-1:0] de_rs2,
  input  logic               de_rs2_used,
  input  logic [REGBITS-1:0] de_rd,
  input  logic               de_wr_reg,
  input  logic               agex_br_redirect,
  input  logic               wb_wr_en,
  input  logic [REGBITS-1:0] wb_rd,
  output logic               stall_DE,
  output logic               issue_DE,
  output logic [NREGS-1:0]   busy_vec,
`ifdef SB_STALL_CNT_EN
  output logic [31:0]        sb_stall_cnt,
`endif
  output logic               sb_error
);
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);

  logic [NREGS-1:0][CNT_BITS-1:0] cnt;
  logic [NREGS-1:0]               wb_hit, inc, uflow;
  logic                           rs1_pend, rs2_pend, raw, waw;
  logic                           sb_error_q, sb_error_d;

  // Register 0 is hardwired zero: no slot, never busy, never retires.
  assign cnt[0]      = '0;
  assign busy_vec[0] = 1'b0;
  assign uflow[0]    = 1'b0;

  always_comb begin
    wb_hit = '0;
    inc    = '0;
    for (int r = 1; r < NREGS; r++) begin
      wb_hit[r] = wb_wr_en & (wb_rd == REGBITS'(r));
      inc[r]    = issue_DE & de_wr_reg & (de_rd == REGBITS'(r));
    end
  end

  genvar g;
  generate
    for (g = 1; g < NREGS; g++) begin : g_slot
      de_sb_slot #(.CNT_BITS(CNT_BITS)) u_slot (
        .clk       (clk),
        .reset     (reset),
        .inc       (inc[g]),
        .wb_hit    (wb_hit[g]),
        .cnt       (cnt[g]),
        .busy      (busy_vec[g]),
        .underflow (uflow[g])
      );
    end
  endgenerate

  // A same-cycle retire counts as resolved since the register file writes before read.
  always_comb begin
    rs1_pend   = de_rs1_used & (cnt[de_rs1] != '0) & ~(wb_hit[de_rs1] & (cnt[de_rs1] == CNT_ONE));
    rs2_pend   = de_rs2_used & (cnt[de_rs2] != '0) & ~(wb_hit[de_rs2] & (cnt[de_rs2] == CNT_ONE));
    raw        = rs1_pend | rs2_pend;
    waw        = de_wr_reg & (de_rd != '0) & (cnt[de_rd] == CNT_MAX) & ~wb_hit[de_rd];
    stall_DE   = de_valid & ~agex_br_redirect & (raw | waw);
    issue_DE   = de_valid & ~agex_br_redirect & ~stall_DE;
    sb_error_d = sb_error_q | (|uflow);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sb_error_q <= 1'b0;
    else        sb_error_q <= sb_error_d;
  end
  assign sb_error = sb_error_q;

`ifdef SB_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_DE && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end
  assign sb_stall_cnt = stall_cnt_q;
`endif
endmodule

// File: doc/de_scoreboard.md
Name: de_scoreboard

Overview:
- Decode-side consumer of the AGEX-to-DE feedback path.
- Tracks in-flight register writes between issue from DE and retirement in WB.
- Asserts the DE stall when a source operand is still pending.
- Suppresses issue when AGEX signals a branch redirect.
- Counts stall cycles for performance analysis.

Parameters:
NREGS, 32, number of architectural registers; register 0 is hardwired zero
REGBITS, 5, register index width (log2 NREGS)
CNT_BITS, 2, per-register pending-write counter width; max in-flight writes per register = 2^CNT_BITS-1

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
de_valid  in  1  valid instruction present in DE
de_rs1  in  REGBITS  source 1 index
de_rs1_used  in  1  instruction reads rs1
de_rs2  in  REGBITS  source 2 index
de_rs2_used  in  1  instruction reads rs2
de_rd  in  REGBITS  destination index
de_wr_reg  in  1  instruction writes rd
agex_br_redirect  in  1  AGEX redirect this cycle; squashes the DE instruction
wb_wr_en  in  1  WB retires a register write this cycle
wb_rd  in  REGBITS  WB destination index
stall_DE  out  1  combinational; hold the FE and DE latches
issue_DE  out  1  combinational; the DE instruction advances into AGEX this cycle
busy_vec  out  NREGS  registered; bit r = (cnt[r] != 0); bit 0 always 0
sb_error  out  1  registered, sticky; retire-with-zero-count underflow

Behaviour:
- State: cnt[r] is CNT_BITS wide for r = 1..NREGS-1. Register 0 has no counter and is never busy; rd = 0 never increments.
- Reset (reset = 0, asynchronous):
  - all cnt = 0, busy_vec = 0, sb_error = 0, stall counter = 0.
  - Outputs are valid in the first cycle after deassertion.
- Retire (wb_hit):
  - wb_hit(r) = wb_wr_en & (wb_rd == r) & (r != 0).
  - Effective count: eff(r) = cnt[r] - wb_hit(r).
  - A same-cycle WB retire resolves a RAW hazard, because the register file is write-before-read.
- RAW hazard:
  - raw = (de_rs1_used & eff(de_rs1) != 0) | (de_rs2_used & eff(de_rs2) != 0).
- WAW limit:
  - waw = de_wr_reg & (de_rd != 0) & (eff(de_rd) == 2^CNT_BITS-1).
  - The instruction stalls rather than overflowing the counter.
- stall_DE = de_valid & ~agex_br_redirect & (raw | waw).
  - A redirect has priority: the squashed instruction never stalls.
- issue_DE = de_valid & ~agex_br_redirect & ~stall_DE.
- Counter update per register, on the same edge:
  - inc = issue_DE & de_wr_reg & (de_rd == r).
  - dec = wb_hit(r) & (cnt[r] != 0).
  - next = cnt + inc - dec.
  - Simultaneous inc and dec on the same register leaves it unchanged.
- Underflow:
  - wb_hit(r) with cnt[r] == 0 sets sb_error (sticky until reset).
  - The counter stays 0.
- busy_vec is registered from the next-state counters, so it reflects state one cycle after the triggering event.
- Latency:
  - stall_DE and issue_DE are zero-cycle, combinational from inputs and state.
  - Counter effects are visible from the next cycle.
- Redirect:
  - Only DE and FE hold younger instructions, and neither has touched the scoreboard, so no counter rollback is needed.
  - Pending writes from AGEX, MEM and WB still retire normally.
- de_valid = 0: no stall, no issue, counters change only by retire.

Optional Feature:
- Macro: SB_STALL_CNT_EN.
- Defined:
  - Adds output sb_stall_cnt, 32 bits, registered.
  - Increments on every cycle with stall_DE = 1.
  - Saturates at 0xFFFFFFFF; reset to 0.
- Undefined:
  - Port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: hold reset = 0 for 3 cycles with de_valid = 1, rd = 5, then release. Required: busy_vec = 0, sb_error = 0 during reset, and busy_vec[5] = 1 one cycle after the first issue.
- RAW stall: issue rd = 5. Next cycle DE has rs1 = 5, rs1_used = 1. Required: stall_DE = 1 for 3 cycles; in the cycle wb_wr_en = 1 with wb_rd = 5, stall_DE = 0 and issue_DE = 1; busy_vec[5] = 0 afterwards.
- Redirect priority: cnt[7] = 1, DE reads rs2 = 7, agex_br_redirect = 1. Required: stall_DE = 0, issue_DE = 0, cnt unchanged.
- x0 and WAW:
  - rd = 0 issue: busy_vec[0] stays 0.
  - Issue rd = 9 three times with no WB: the fourth rd = 9 issue stalls.
  - Same-cycle WB to 9: the fourth issues and cnt[9] stays at 3.
- Underflow: wb_wr_en = 1, wb_rd = 12, cnt[12] = 0. Required: sb_error = 1 next cycle and held until reset; cnt[12] = 0.
- With SB_STALL_CNT_EN: 4-cycle RAW stall. Required: sb_stall_cnt goes 0 → 4; asynchronous reset mid-stall clears it to 0 immediately.
